uart_tx_arbiter: RTL and testbench

Frame-level arbiter that shares the single UART transmitter between two byte-stream requesters, such as the AT-command senders. It grants the transmitter to one requester for a whole frame, which ends on the byte flagged `last`. Frames from different requesters are never interleaved. Bytes are forwarded one at a time, and the next byte is not fetched until the UART reports completion. A stall timeout recovers the transmitter from a requester that stops mid-frame.

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte-stream requesters, one whole frame per grant.
// Bytes go out one at a time; a requester stalling mid-frame loses the grant after TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_send_en,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic       frame_done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        last_q, last_d;
  logic [31:0] stall_q, stall_d;
  logic        send_q, send_d;
  logic        fdone_q, fdone_d;
  logic        terr_q, terr_d;

  logic        sel_valid;
  logic [7:0]  sel_data;
  logic        sel_last;
  logic        owner;

  assign owner     = grant_q[1];
  assign sel_valid = owner ? req1_valid : req0_valid;
  assign sel_data  = owner ? req1_data  : req0_data;
  assign sel_last  = owner ? req1_last  : req0_last;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    last_d       = last_q;
    stall_d      = stall_q;
    send_d       = 1'b0;
    fdone_d      = 1'b0;
    terr_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // last_grant holds the index of the previous owner; on a tie the other side wins
        if (req0_valid && req1_valid) begin
          grant_d = last_grant_q ? 2'b01 : 2'b10;
          state_d = S_FETCH;
        end else if (req0_valid) begin
          grant_d = 2'b01;
          state_d = S_FETCH;
        end else if (req1_valid) begin
          grant_d = 2'b10;
          state_d = S_FETCH;
        end
        stall_d = '0;
      end
      S_FETCH: begin
        if (sel_valid) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          stall_d   = '0;
          send_d    = 1'b1;
          state_d   = S_ISSUE;
        end else if (stall_q == 32'(TIMEOUT_CYC - 1)) begin
          terr_d       = 1'b1;
          last_grant_d = owner;
          grant_d      = 2'b00;
          stall_d      = '0;
          state_d      = S_IDLE;
        end else begin
          stall_d = stall_q + 32'd1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            fdone_d      = 1'b1;
            last_grant_d = owner;
            grant_d      = 2'b00;
            state_d      = S_IDLE;
          end else begin
            stall_d = '0;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      tx_data_q    <= 8'h00;
      last_q       <= 1'b0;
      stall_q      <= '0;
      send_q       <= 1'b0;
      fdone_q      <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      last_q       <= last_d;
      stall_q      <= stall_d;
      send_q       <= send_d;
      fdone_q      <= fdone_d;
      terr_q       <= terr_d;
    end
  end

  assign req0_ready  = (state_q == S_FETCH) && grant_q[0];
  assign req1_ready  = (state_q == S_FETCH) && grant_q[1];
  assign tx_data     = tx_data_q;
  assign tx_send_en  = send_q;
  assign grant       = grant_q;
  assign frame_done  = fdone_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter: a frame-order model fills the expected
// byte queue, a monitor pops it on every tx_send_en and checks frame_done / timeout_err.
module tb_uart_tx_arbiter;
  localparam int TO = 16;

  logic clk, rst_n;
  logic req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, tx_data;
  logic tx_send_en, tx_done, frame_done, timeout_err;
  logic [1:0] grant;
  logic uart_done, spur;

  typedef struct {logic [7:0] data; logic last; logic stall;} ent_t;
  typedef struct {logic owner; logic [7:0] data; logic last;} exp_t;

  ent_t q0[$], q1[$], s0[$], s1[$], m0[$], m1[$];
  exp_t sbq[$];
  int checks = 0, errors = 0, cyc = 0;
  int n_sends = 0, n_fdone = 0, exp_fdone = 0, n_terr = 0, to_exp = -1;
  int mdl_last = 1, dly_fix = 10;
  bit dly_rand = 0, hold0 = 0, hold1 = 0, pend_last = 0, prev_send = 0, prev_done = 0;

  uart_tx_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_send_en(tx_send_en), .tx_done(tx_done),
    .grant(grant), .frame_done(frame_done), .timeout_err(timeout_err));

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tx_done = uart_done | spur;

  task automatic chk(input string nm, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, detail);
    end
  endtask

  // Requester drivers: present the queue head, pop it after an accepting edge.
  task automatic drive_req(input int k);
    bit acc;
    ent_t e;
    if (k == 0) begin req0_valid = 0; req0_data = 0; req0_last = 0; end
    else begin req1_valid = 0; req1_data = 0; req1_last = 0; end
    forever begin
      @(negedge clk);
      acc = (k == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
      @(posedge clk); #1;
      if (k == 0) begin
        if (acc && q0.size() > 0) begin e = q0.pop_front(); if (e.stall) hold0 = 1; end
        req0_valid = (q0.size() > 0) && !hold0;
        if (q0.size() > 0) begin req0_data = q0[0].data; req0_last = q0[0].last; end
      end else begin
        if (acc && q1.size() > 0) begin e = q1.pop_front(); if (e.stall) hold1 = 1; end
        req1_valid = (q1.size() > 0) && !hold1;
        if (q1.size() > 0) begin req1_data = q1[0].data; req1_last = q1[0].last; end
      end
    end
  endtask
  initial drive_req(0);
  initial drive_req(1);

  // UART model: tx_done some cycles after each send.
  initial begin
    int cnt;
    cnt = 0; uart_done = 0;
    forever begin
      @(negedge clk);
      uart_done = 0;
      if (cnt > 0) begin cnt--; if (cnt == 0) uart_done = 1; end
      if (tx_send_en) cnt = dly_rand ? int'($urandom_range(1, 12)) : dly_fix;
    end
  end

  // Monitor
  initial begin
    exp_t e;
    logic [1:0] eg;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin prev_send = 0; prev_done = 0; continue; end
      if (tx_send_en) begin
        if (sbq.size() == 0)
          chk("send", 0, $sformatf("unexpected byte %h grant %b, required no send", tx_data, grant));
        else begin
          e = sbq.pop_front();
          eg = e.owner ? 2'b10 : 2'b01;
          chk("send", tx_data === e.data && grant === eg && !prev_send,
              $sformatf("data %h grant %b back2back %0b, required data %h grant %b back2back 0",
                        tx_data, grant, prev_send, e.data, eg));
          pend_last = e.last;
          n_sends++;
        end
      end
      if (frame_done) begin
        chk("frame_done", pend_last && grant === 2'b00 && prev_done,
            $sformatf("after_last %0b grant %b prev_done %0b, required 1 00 1", pend_last, grant, prev_done));
        pend_last = 0;
        n_fdone++;
      end
      if (timeout_err) begin
        chk("timeout_err", cyc == to_exp && grant === 2'b00,
            $sformatf("cycle %0d grant %b, required cycle %0d grant 00", cyc, grant, to_exp));
        to_exp = -1;
        n_terr++;
      end
      prev_send = tx_send_en;
      prev_done = tx_done;
    end
  end

  task automatic add_byte(input int k, input logic [7:0] d, input logic l, input logic st);
    ent_t e;
    e.data = d; e.last = l; e.stall = st;
    if (k == 0) begin s0.push_back(e); m0.push_back(e); end
    else begin s1.push_back(e); m1.push_back(e); end
  endtask

  task automatic add_frame(input int k, input int len);
    for (int i = 0; i < len; i++) add_byte(k, 8'($urandom), i == len - 1, 1'b0);
  endtask

  // Reference: whole frames, alternating on ties, owner not served last goes first.
  task automatic plan();
    exp_t x;
    int pick;
    bit done;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) pick = (mdl_last == 1) ? 0 : 1;
      else pick = (m0.size() > 0) ? 0 : 1;
      done = 0;
      while (!done) begin
        ent_t e;
        e = (pick == 0) ? m0.pop_front() : m1.pop_front();
        x.owner = pick[0]; x.data = e.data; x.last = e.last;
        sbq.push_back(x);
        done = e.last;
      end
      exp_fdone++;
      mdl_last = pick;
    end
  endtask

  task automatic launch();
    @(negedge clk);
    q0 = s0; q1 = s1;
    s0.delete(); s1.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((sbq.size() > 0 || q0.size() > 0 || q1.size() > 0 || grant != 2'b00) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk(nm, n < 5000, $sformatf("still busy after %0d cycles, required idle", n));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string nm);
    chk(nm, grant === 2'b00 && tx_send_en === 1'b0 && tx_data === 8'h00 && frame_done === 1'b0 &&
            timeout_err === 1'b0 && req0_ready === 1'b0 && req1_ready === 1'b0,
        $sformatf("grant %b send %b data %h fdone %b terr %b rdy %b%b, required all zero",
                  grant, tx_send_en, tx_data, frame_done, timeout_err, req0_ready, req1_ready));
  endtask

  initial begin
    int n0, n;
    rst_n = 0; spur = 0;

    // Tie after reset: both valid before release, requester 0 first.
    add_frame(0, 3); add_frame(1, 3);
    plan(); launch();
    repeat (2) @(negedge clk);
    #1 check_reset_outs("reset_state");
    @(negedge clk); rst_n = 1;
    wait_idle("tie");

    // Fairness: requester 0 keeps frames queued, requester 1 has one pending.
    for (int i = 0; i < 3; i++) add_frame(0, 2);
    add_frame(1, 2);
    plan(); launch();
    wait_idle("fairness");

    // Single "AT\r\n" frame, UART 10 cycles per byte.
    add_byte(0, 8'h41, 0, 0); add_byte(0, 8'h54, 0, 0);
    add_byte(0, 8'h0D, 0, 0); add_byte(0, 8'h0A, 1, 0);
    plan(); launch();
    wait_idle("single_frame");

    // Spurious tx_done while idle.
    n0 = n_sends; n = n_fdone;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); spur = 1; @(negedge clk); spur = 0;
    end
    repeat (4) @(negedge clk);
    chk("spur_idle", grant === 2'b00 && n_sends == n0 && n_fdone == n,
        $sformatf("grant %b sends +%0d fdone +%0d, required 00 +0 +0", grant, n_sends - n0, n_fdone - n));

    // Spurious tx_done while FETCH waits on a stalled requester.
    add_byte(0, 8'hA5, 0, 1); add_byte(0, 8'h5A, 1, 0);
    plan(); n0 = n_sends; launch();
    n = 0;
    while (!(n_sends == n0 + 1 && req0_ready) && n < 200) begin @(negedge clk); #1; n++; end
    chk("spur_fetch_reach", n < 200, "FETCH not reached, required FETCH after first byte");
    spur = 1; @(negedge clk); spur = 0;
    repeat (3) @(negedge clk);
    #1 chk("spur_fetch", req0_ready === 1'b1 && grant === 2'b01 && n_sends == n0 + 1,
           $sformatf("ready %b grant %b sends +%0d, required 1 01 +1", req0_ready, grant, n_sends - n0));
    hold0 = 0;
    wait_idle("spur_fetch_done");

    // Timeout: requester 0 stalls after one byte, requester 1 then served.
    dly_fix = 6;
    add_byte(0, 8'h11, 0, 1); add_byte(0, 8'h22, 0, 0); add_byte(0, 8'h33, 1, 0);
    m0.delete();
    sbq.push_back('{1'b0, 8'h11, 1'b0});
    launch();
    n = 0;
    while (grant !== 2'b01 && n < 100) begin @(negedge clk); n++; end
    add_frame(1, 3);
    plan(); launch();
    n = 0;
    while (!uart_done && n < 100) begin @(negedge clk); #1; n++; end
    to_exp = cyc + 1 + TO;
    n0 = n_terr;
    n = 0;
    while ((sbq.size() > 0 || q1.size() > 0 || grant != 2'b00) && n < 2000) begin @(negedge clk); n++; end
    chk("timeout_flow", n < 2000 && n_terr == n0 + 1,
        $sformatf("timeouts +%0d busy %0d, required +1 and idle", n_terr - n0, n));
    q0.delete(); hold0 = 0;
    repeat (3) @(negedge clk);

    // Random rounds with random UART latency.
    dly_rand = 1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 2; k++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) add_frame(k, $urandom_range(1, 4));
      end
      plan(); launch();
      wait_idle("random");
    end

    // Reset during WAIT_DONE of byte 2.
    dly_rand = 0; dly_fix = 10;
    add_frame(0, 4); plan();
    n0 = n_sends; launch();
    n = 0;
    while (n_sends < n0 + 2 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_n = 0;
    q0.delete(); q1.delete(); sbq.delete();
    hold0 = 0; hold1 = 0; pend_last = 0;
    exp_fdone--; mdl_last = 1;
    #1 check_reset_outs("reset_mid_frame");
    repeat (12) @(negedge clk);
    add_frame(1, 2); add_frame(0, 2);
    plan(); launch();
    @(negedge clk); rst_n = 1;
    wait_idle("after_reset");

    chk("frame_count", n_fdone == exp_fdone && n_terr == 1 && sbq.size() == 0,
        $sformatf("frames %0d timeouts %0d left %0d, required %0d 1 0", n_fdone, n_terr, sbq.size(), exp_fdone));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end
endmodule
